if_id_queue: RTL and testbench

Instruction queue between the fetch stage and the decode stage of the pipelined RV32I core. Fetch pushes one {instruction, PC, halt} entry per cycle; decode pops the head under a valid/ready handshake. A redirect (branch/jump resolved in MEM) flushes every queued entry. A halt entry blocks further enqueues until it is either flushed or consumed.

---
 rtl/if_id_queue_if.sv | 32 +++
 rtl/if_id_queue.sv | 90 +++++++++
 tb/tb_if_id_queue.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF->ID instruction queue.
// The queue itself takes the slave side; the surrounding pipeline takes master.
interface if_id_queue_if #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            if_valid;
  logic [XLEN-1:0] if_instruction;
  logic [XLEN-1:0] if_pc;
  logic            if_halt;
  logic            if_ready;
  logic            flush;
  logic            id_valid;
  logic [XLEN-1:0] id_instruction;
  logic [XLEN-1:0] id_pc;
  logic            id_halt;
  logic            id_ready;
  logic [CW-1:0]   count;
  logic            halted;

  modport slave (
    input  if_valid, if_instruction, if_pc, if_halt, flush, id_ready,
    output if_ready, id_valid, id_instruction, id_pc, id_halt, count, halted
  );

  modport master (
    output if_valid, if_instruction, if_pc, if_halt, flush, id_ready,
    input  if_ready, id_valid, id_instruction, id_pc, id_halt, count, halted
  );
endinterface

// File: rtl/if_id_queue.sv
// IF->ID instruction queue: circular buffer of {instruction, pc, halt} with
// flush-on-redirect and halt gating of further fetches.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic          clk,
  input  logic          rst,
  if_id_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0]  instr_mem [DEPTH];
  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [DEPTH-1:0] halt_mem;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          halt_pending;
  logic          halted_q;

  logic full;
  logic empty;
  logic if_ready_w;
  logic id_valid_w;
  logic push;
  logic pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Halted also gates fetch so nothing past a consumed halt is ever accepted.
  assign if_ready_w = !full && !halt_pending && !halted_q && !bus.flush;
  assign id_valid_w = !empty && !bus.flush;

  assign push = bus.if_valid && if_ready_w;
  assign pop  = id_valid_w && bus.id_ready;

  assign bus.if_ready       = if_ready_w;
  assign bus.id_valid       = id_valid_w;
  assign bus.id_instruction = id_valid_w ? instr_mem[rd_ptr] : NOP;
  assign bus.id_pc          = id_valid_w ? pc_mem[rd_ptr]    : '0;
  assign bus.id_halt        = id_valid_w ? halt_mem[rd_ptr]  : 1'b0;
  assign bus.count          = count_q;
  assign bus.halted         = halted_q;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= bus.if_instruction;
      pc_mem[wr_ptr]    <= bus.if_pc;
      halt_mem[wr_ptr]  <= bus.if_halt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      halt_pending <= 1'b0;
      halted_q     <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      halt_pending <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      // A queued halt blocks pushes, so popping a halt never coincides with pushing one.
      if (pop && halt_mem[rd_ptr]) begin
        halted_q     <= 1'b1;
        halt_pending <= 1'b0;
      end else if (push && bus.if_halt) begin
        halt_pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table, hand-written halt/flush/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_if_id_queue;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;

  if_id_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    bit          h;
  } ent_t;

  ent_t mq[$];
  bit   m_hp;
  bit   m_halted;

  bit          d_v, d_h, d_fl, d_rdy;
  logic [31:0] d_ins, d_pc;
  bit          e_ifr, e_idv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_hp     = 0;
    m_halted = 0;
  endtask

  // Drive one cycle of inputs after the falling edge and compare against the model.
  task automatic apply(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit h, input bit fl, input bit rdy);
    @(negedge clk);
    d_v = v; d_ins = ins; d_pc = pc; d_h = h; d_fl = fl; d_rdy = rdy;
    bus.if_valid       = v;
    bus.if_instruction = ins;
    bus.if_pc          = pc;
    bus.if_halt        = h;
    bus.flush          = fl;
    bus.id_ready       = rdy;
    #1;
    e_ifr = (mq.size() < DEPTH) && !m_hp && !m_halted && !fl;
    e_idv = (mq.size() > 0) && !fl;
    check("m_if_ready", 32'(bus.if_ready), 32'(e_ifr));
    check("m_id_valid", 32'(bus.id_valid), 32'(e_idv));
    check("m_count",    32'(bus.count),    32'(mq.size()));
    check("m_halted",   32'(bus.halted),   32'(m_halted));
    if (e_idv) begin
      check("m_id_instr", bus.id_instruction, mq[0].ins);
      check("m_id_pc",    bus.id_pc,          mq[0].pc);
      check("m_id_halt",  32'(bus.id_halt),   32'(mq[0].h));
    end else begin
      check("m_id_instr_idle", bus.id_instruction, NOP);
      check("m_id_pc_idle",    bus.id_pc,          32'h0);
      check("m_id_halt_idle",  32'(bus.id_halt),   32'h0);
    end
  endtask

  task automatic tick();
    ent_t e;
    @(posedge clk);
    if (d_fl) begin
      mq.delete();
      m_hp = 0;
    end else begin
      if (e_idv && d_rdy) begin
        e = mq.pop_front();
        if (e.h) begin
          m_halted = 1;
          m_hp     = 0;
        end
      end
      if (d_v && e_ifr) begin
        e.ins = d_ins; e.pc = d_pc; e.h = d_h;
        mq.push_back(e);
        if (d_h) m_hp = 1;
      end
    end
  endtask

  task automatic idle_inputs();
    bus.if_valid = 0; bus.if_instruction = '0; bus.if_pc = '0;
    bus.if_halt = 0; bus.flush = 0; bus.id_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 0;
    #2;
    check("rst_count",    32'(bus.count),    32'h0);
    check("rst_id_valid", 32'(bus.id_valid), 32'h0);
    check("rst_id_instr", bus.id_instruction, NOP);
    check("rst_id_pc",    bus.id_pc,          32'h0);
    check("rst_id_halt",  32'(bus.id_halt),   32'h0);
    check("rst_halted",   32'(bus.halted),    32'h0);
    #1 rst = 1;
    model_reset();
    #1 check("rst_if_ready", 32'(bus.if_ready), 32'h1);
  endtask

  typedef struct {
    bit          v;
    logic [31:0] pc;
    logic [31:0] ins;
    bit          fl;
    bit          rdy;
    bit          e_ifr;
    bit          e_idv;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    int          e_cnt;
  } vec_t;

  function automatic vec_t mk(bit v, logic [31:0] pc, logic [31:0] ins, bit fl, bit rdy,
                              bit eifr, bit eidv, logic [31:0] epc, logic [31:0] eins, int ecnt);
    vec_t r;
    r.v = v; r.pc = pc; r.ins = ins; r.fl = fl; r.rdy = rdy;
    r.e_ifr = eifr; r.e_idv = eidv; r.e_pc = epc; r.e_ins = eins; r.e_cnt = ecnt;
    return r;
  endfunction

  function automatic logic [31:0] bi(logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  vec_t tbl[19];

  initial begin
    logic [31:0] i0, i1, i2;
    i0 = 32'h0050_0093; i1 = 32'h00a0_0113; i2 = 32'h0020_81b3;
    // Stream, backpressure, then flush with a full queue.
    tbl[0]  = mk(1, 32'h0,   i0,          0, 1, 1, 0, 32'h0,   NOP,          0);
    tbl[1]  = mk(1, 32'h4,   i1,          0, 1, 1, 1, 32'h0,   i0,           1);
    tbl[2]  = mk(1, 32'h8,   i2,          0, 1, 1, 1, 32'h4,   i1,           1);
    tbl[3]  = mk(0, 32'h0,   32'h0,       0, 1, 1, 1, 32'h8,   i2,           1);
    tbl[4]  = mk(0, 32'h0,   32'h0,       0, 0, 1, 0, 32'h0,   NOP,          0);
    tbl[5]  = mk(1, 32'h0,   bi(32'h0),   0, 0, 1, 0, 32'h0,   NOP,          0);
    tbl[6]  = mk(1, 32'h4,   bi(32'h4),   0, 0, 1, 1, 32'h0,   bi(32'h0),    1);
    tbl[7]  = mk(1, 32'h8,   bi(32'h8),   0, 0, 0, 1, 32'h0,   bi(32'h0),    2);
    tbl[8]  = mk(1, 32'h8,   bi(32'h8),   0, 1, 0, 1, 32'h0,   bi(32'h0),    2);
    tbl[9]  = mk(1, 32'h8,   bi(32'h8),   0, 0, 1, 1, 32'h4,   bi(32'h4),    1);
    tbl[10] = mk(0, 32'h0,   32'h0,       0, 1, 0, 1, 32'h4,   bi(32'h4),    2);
    tbl[11] = mk(0, 32'h0,   32'h0,       0, 1, 1, 1, 32'h8,   bi(32'h8),    1);
    tbl[12] = mk(0, 32'h0,   32'h0,       0, 0, 1, 0, 32'h0,   NOP,          0);
    tbl[13] = mk(1, 32'h20,  bi(32'h20),  0, 0, 1, 0, 32'h0,   NOP,          0);
    tbl[14] = mk(1, 32'h24,  bi(32'h24),  0, 0, 1, 1, 32'h20,  bi(32'h20),   1);
    tbl[15] = mk(1, 32'h28,  bi(32'h28),  1, 0, 0, 0, 32'h0,   NOP,          2);
    tbl[16] = mk(1, 32'h100, bi(32'h100), 0, 0, 1, 0, 32'h0,   NOP,          0);
    tbl[17] = mk(0, 32'h0,   32'h0,       0, 1, 1, 1, 32'h100, bi(32'h100),  1);
    tbl[18] = mk(0, 32'h0,   32'h0,       0, 0, 1, 0, 32'h0,   NOP,          0);

    rst = 0;
    idle_inputs();
    model_reset();
    #12;
    do_reset();

    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].v, tbl[i].ins, tbl[i].pc, 1'b0, tbl[i].fl, tbl[i].rdy);
      check($sformatf("t%0d_if_ready", i), 32'(bus.if_ready), 32'(tbl[i].e_ifr));
      check($sformatf("t%0d_id_valid", i), 32'(bus.id_valid), 32'(tbl[i].e_idv));
      check($sformatf("t%0d_id_pc", i),    bus.id_pc,          tbl[i].e_pc);
      check($sformatf("t%0d_id_instr", i), bus.id_instruction, tbl[i].e_ins);
      check($sformatf("t%0d_count", i),    32'(bus.count),     32'(tbl[i].e_cnt));
      tick();
    end

    // Halt entry flushed before decode sees it: fetch resumes, halted stays 0.
    apply(1, 32'hC000_0040, 32'h40, 1, 0, 0); tick();
    apply(1, 32'hC000_0044, 32'h44, 0, 0, 0);
    check("halt_blocks_push", 32'(bus.if_ready), 32'h0);
    tick();
    apply(0, 32'h0, 32'h0, 0, 1, 0); tick();
    apply(1, 32'hC000_0048, 32'h48, 0, 0, 0);
    check("halt_flush_resume", 32'(bus.if_ready), 32'h1);
    check("halt_flush_halted", 32'(bus.halted),   32'h0);
    tick();
    apply(0, 32'h0, 32'h0, 0, 0, 1); tick();

    // Asynchronous reset between edges with a full queue.
    apply(1, 32'hD000_0000, 32'h200, 0, 0, 0); tick();
    apply(1, 32'hD000_0004, 32'h204, 0, 0, 0); tick();
    apply(0, 32'h0, 32'h0, 0, 0, 0);
    check("pre_arst_count", 32'(bus.count), 32'h2);
    idle_inputs();
    #2 rst = 0;
    #1;
    check("arst_count",    32'(bus.count),    32'h0);
    check("arst_id_valid", 32'(bus.id_valid), 32'h0);
    check("arst_id_instr", bus.id_instruction, NOP);
    #1 rst = 1;
    model_reset();

    // Randomized traffic in independent reset-separated rounds.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        logic [31:0] pc;
        pc = $urandom & 32'hFFFF_FFFC;
        apply($urandom_range(0, 3) != 0, $urandom, pc,
              $urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 2) != 0);
        tick();
      end
    end

    // Halt consumed by decode: halted sticks, fetch stays blocked until reset.
    do_reset();
    apply(1, 32'hE000_0010, 32'h10, 1, 0, 0); tick();
    apply(1, 32'hE000_0014, 32'h14, 0, 0, 1);
    check("halt_head_flag", 32'(bus.id_halt),  32'h1);
    check("halt_head_pc",   bus.id_pc,         32'h10);
    check("halt_refuse",    32'(bus.if_ready), 32'h0);
    tick();
    apply(1, 32'hE000_0018, 32'h18, 0, 0, 1);
    check("halted_set",       32'(bus.halted),   32'h1);
    check("halted_if_ready",  32'(bus.if_ready), 32'h0);
    check("halted_count",     32'(bus.count),    32'h0);
    tick();
    apply(1, 32'hE000_001C, 32'h1C, 0, 1, 1);
    check("halted_after_flush", 32'(bus.halted), 32'h1);
    tick();
    do_reset();
    check("halted_cleared", 32'(bus.halted), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
